// File: rtl/memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lisp_defs (package)
// Description : Shared word/address widths, NIL encoding and arbiter states.
// Revision    : 1.0
// ============================================================================
package lisp_defs;

  localparam int MemAddrWidth = 12;
  localparam int WordWidth    = 16;

  localparam logic [WordWidth-1:0] LISP_NIL = 16'h0000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ_WAIT = 3'd1,
    CONS_WAIT = 3'd2,
    CONS_PTR  = 3'd3,
    ACK       = 3'd4
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/memory_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first requester at or after
//               the pointer, wrapping. One-hot grant plus its index.
// Revision    : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NumClients = 2,
  parameter int PtrWidth   = 1
) (
  input  logic [NumClients-1:0] req,
  input  logic [PtrWidth-1:0]   ptr,
  output logic                  any,
  output logic [NumClients-1:0] grant,
  output logic [PtrWidth-1:0]   grant_idx
);

  logic [PtrWidth-1:0] w_idx;

  always_comb begin
    any       = 1'b0;
    grant     = '0;
    grant_idx = '0;
    w_idx     = '0;
    for (int off = 0; off < NumClients; off++) begin
      w_idx = PtrWidth'((int'(ptr) + off) % NumClients);
      if (!any && req[w_idx]) begin
        any          = 1'b1;
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Round-robin sharing of the memory read/cons ports among
//               clients, with a cons-latency watchdog.
// Revision    : 1.0
// ============================================================================
module memory_arbiter
  import lisp_defs::*;
#(
  parameter int NumClients  = 2,
  parameter int ConsTimeout = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NumClients-1:0]            client_req,
  input  logic [NumClients-1:0]            client_is_cons,
  input  logic [NumClients*MemAddrWidth-1:0] client_addr,
  input  logic [NumClients*WordWidth-1:0]  client_car,
  input  logic [NumClients*WordWidth-1:0]  client_cdr,
  output logic [NumClients-1:0]            client_ack,
  output logic                             client_err,
  output logic [WordWidth-1:0]             resp_data,
  output logic                             busy,
  output logic                             mem_req,
  output logic [MemAddrWidth-1:0]          mem_addr,
  input  logic                             mem_data_ready,
  input  logic [WordWidth-1:0]             mem_data_out,
  output logic                             mem_cons_en,
  output logic [WordWidth-1:0]             mem_cons_car,
  output logic [WordWidth-1:0]             mem_cons_cdr,
  input  logic                             mem_cons_done,
  input  logic [WordWidth-1:0]             mem_cons_ptr
);

  localparam int c_ptr_w = (NumClients > 1) ? $clog2(NumClients) : 1;
  localparam int c_cnt_w = $clog2(ConsTimeout + 1);
  localparam logic [c_ptr_w-1:0] c_last_client = c_ptr_w'(NumClients - 1);
  localparam logic [c_cnt_w-1:0] c_timeout     = c_cnt_w'(ConsTimeout);

  arb_state_t                r_state, w_state_nxt;
  logic [c_ptr_w-1:0]        r_ptr, w_ptr_nxt;
  logic [NumClients-1:0]     r_grant_oh, w_grant_oh_nxt;
  logic [c_cnt_w-1:0]        r_cnt, w_cnt_nxt;

  logic [NumClients-1:0]     w_ack_nxt;
  logic                      w_err_nxt;
  logic [WordWidth-1:0]      w_resp_nxt;
  logic                      w_busy_nxt;
  logic                      w_mem_req_nxt;
  logic [MemAddrWidth-1:0]   w_addr_nxt;
  logic                      w_cons_en_nxt;
  logic [WordWidth-1:0]      w_car_nxt;
  logic [WordWidth-1:0]      w_cdr_nxt;

  logic                      w_any;
  logic [NumClients-1:0]     w_grant;
  logic [c_ptr_w-1:0]        w_grant_idx;

  rr_arbiter #(
    .NumClients (NumClients),
    .PtrWidth   (c_ptr_w)
  ) u_rr_arbiter (
    .req       (client_req),
    .ptr       (r_ptr),
    .any       (w_any),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_grant_oh_nxt = r_grant_oh;
    w_cnt_nxt      = r_cnt;
    w_ack_nxt      = '0;
    w_err_nxt      = 1'b0;
    w_resp_nxt     = resp_data;
    w_mem_req_nxt  = mem_req;
    w_addr_nxt     = mem_addr;
    w_cons_en_nxt  = 1'b0;
    w_car_nxt      = mem_cons_car;
    w_cdr_nxt      = mem_cons_cdr;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_oh_nxt = w_grant;
          w_ptr_nxt      = (w_grant_idx == c_last_client) ? '0
                                                          : w_grant_idx + c_ptr_w'(1);
          w_addr_nxt     = client_addr[w_grant_idx*MemAddrWidth +: MemAddrWidth];
          w_car_nxt      = client_car[w_grant_idx*WordWidth +: WordWidth];
          w_cdr_nxt      = client_cdr[w_grant_idx*WordWidth +: WordWidth];
          if (client_is_cons[w_grant_idx]) begin
            w_cons_en_nxt = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = CONS_WAIT;
          end else begin
            w_mem_req_nxt = 1'b1;
            w_state_nxt   = READ_WAIT;
          end
        end
      end

      READ_WAIT: begin
        if (mem_data_ready) begin
          w_resp_nxt    = mem_data_out;
          w_mem_req_nxt = 1'b0;
          w_ack_nxt     = r_grant_oh;
          w_state_nxt   = ACK;
        end
      end

      // A done arriving on the same cycle the watchdog expires still wins.
      CONS_WAIT: begin
        if (mem_cons_done) begin
          w_state_nxt = CONS_PTR;
        end else if (r_cnt == c_timeout) begin
          w_resp_nxt  = LISP_NIL;
          w_err_nxt   = 1'b1;
          w_ack_nxt   = r_grant_oh;
          w_state_nxt = ACK;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end

      CONS_PTR: begin
        w_resp_nxt  = mem_cons_ptr;
        w_ack_nxt   = r_grant_oh;
        w_state_nxt = ACK;
      end

      ACK: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_grant_oh   <= '0;
      r_cnt        <= '0;
      client_ack   <= '0;
      client_err   <= 1'b0;
      resp_data    <= '0;
      busy         <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_cons_en  <= 1'b0;
      mem_cons_car <= '0;
      mem_cons_cdr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_grant_oh   <= w_grant_oh_nxt;
      r_cnt        <= w_cnt_nxt;
      client_ack   <= w_ack_nxt;
      client_err   <= w_err_nxt;
      resp_data    <= w_resp_nxt;
      busy         <= w_busy_nxt;
      mem_req      <= w_mem_req_nxt;
      mem_addr     <= w_addr_nxt;
      mem_cons_en  <= w_cons_en_nxt;
      mem_cons_car <= w_car_nxt;
      mem_cons_cdr <= w_cdr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Scoreboard bench for memory_arbiter with a behavioural memory.
// Revision    : 1.0
// ============================================================================
module tb_memory_arbiter;

  localparam int NC      = 2;
  localparam int TIMEOUT = 16;
  localparam logic [10:0] HEAP_START = 11'd1;

  typedef struct packed {
    logic [NC-1:0] ack;
    logic          err;
    logic [15:0]   data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     client_req;
  logic [NC-1:0]     client_is_cons;
  logic [NC*12-1:0]  client_addr;
  logic [NC*16-1:0]  client_car;
  logic [NC*16-1:0]  client_cdr;
  logic [NC-1:0]     client_ack;
  logic              client_err;
  logic [15:0]       resp_data;
  logic              busy;
  logic              mem_req;
  logic [11:0]       mem_addr;
  logic              mem_data_ready;
  logic [15:0]       mem_data_out;
  logic              mem_cons_en;
  logic [15:0]       mem_cons_car;
  logic [15:0]       mem_cons_cdr;
  logic              mem_cons_done;
  logic [15:0]       mem_cons_ptr;

  logic              block_done;
  logic [10:0]       heap;
  logic [15:0]       mem [0:4095] = '{1: 16'hBEEF, default: 16'h0000};

  exp_t exp_q[$];
  int   main_total = 0, main_bad = 0;
  int   mon_total  = 0, mon_bad  = 0;
  int   total, bad;

  always #5 clk = ~clk;

  memory_arbiter #(.NumClients(NC), .ConsTimeout(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .client_req     (client_req),
    .client_is_cons (client_is_cons),
    .client_addr    (client_addr),
    .client_car     (client_car),
    .client_cdr     (client_cdr),
    .client_ack     (client_ack),
    .client_err     (client_err),
    .resp_data      (resp_data),
    .busy           (busy),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_data_ready (mem_data_ready),
    .mem_data_out   (mem_data_out),
    .mem_cons_en    (mem_cons_en),
    .mem_cons_car   (mem_cons_car),
    .mem_cons_cdr   (mem_cons_cdr),
    .mem_cons_done  (mem_cons_done),
    .mem_cons_ptr   (mem_cons_ptr)
  );

  // Single-cycle read; cons cell n stores car at 2n and cdr at 2n+1.
  always @(posedge clk) begin
    if (rst) begin
      mem_data_ready <= 1'b0;
      mem_data_out   <= 16'h0;
      mem_cons_done  <= 1'b0;
      mem_cons_ptr   <= 16'h0;
      heap           <= HEAP_START;
    end else begin
      mem_data_ready <= mem_req && !mem_data_ready;
      if (mem_req && !mem_data_ready) mem_data_out <= mem[mem_addr];
      mem_cons_done <= mem_cons_en && !block_done;
      if (mem_cons_done) begin
        mem_cons_ptr          <= {5'd0, heap};
        mem[{heap, 1'b0}]     <= mem_cons_car;
        mem[{heap, 1'b1}]     <= mem_cons_cdr;
        heap                  <= heap + 11'd1;
      end
    end
  end

  // Monitor: protocol rules every cycle, scoreboard pop on every ack.
  initial begin
    logic prev_en;
    exp_t e;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_total++;
        if (mem_req && mem_cons_en) begin
          mon_bad++;
          $display("FAIL excl: mem_req=%0b mem_cons_en=%0b, required not both", mem_req, mem_cons_en);
        end
        mon_total++;
        if (mem_cons_en && prev_en) begin
          mon_bad++;
          $display("FAIL cons_en_width: mem_cons_en high two cycles, required one");
        end
        mon_total++;
        if (!$onehot0(client_ack)) begin
          mon_bad++;
          $display("FAIL ack_onehot: client_ack=%b, required one-hot or zero", client_ack);
        end
        if (client_ack != '0) begin
          mon_total++;
          if (exp_q.size() == 0) begin
            mon_bad++;
            $display("FAIL unexpected_ack: client_ack=%b, required no ack", client_ack);
          end else begin
            e = exp_q.pop_front();
            if (client_ack != e.ack || client_err != e.err || resp_data != e.data) begin
              mon_bad++;
              $display("FAIL resp: ack=%b err=%0b data=%h, required ack=%b err=%0b data=%h",
                       client_ack, client_err, resp_data, e.ack, e.err, e.data);
            end
          end
        end
      end
      prev_en = mem_cons_en;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    main_total++;
    if (act !== req) begin
      main_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ack"},   32'(client_ack), 32'h0);
    check({name, "_err"},   32'(client_err), 32'h0);
    check({name, "_resp"},  32'(resp_data), 32'h0);
    check({name, "_busy"},  32'(busy), 32'h0);
    check({name, "_mreq"},  32'(mem_req), 32'h0);
    check({name, "_maddr"}, 32'(mem_addr), 32'h0);
    check({name, "_cen"},   32'(mem_cons_en), 32'h0);
    check({name, "_car"},   32'(mem_cons_car), 32'h0);
    check({name, "_cdr"},   32'(mem_cons_cdr), 32'h0);
  endtask

  task automatic issue(input int c, input logic is_cons, input logic [11:0] addr,
                       input logic [15:0] car, input logic [15:0] cdr,
                       input logic push, input logic err, input logic [15:0] data);
    exp_t e;
    client_is_cons[c]     = is_cons;
    client_addr[c*12 +: 12] = addr;
    client_car[c*16 +: 16]  = car;
    client_cdr[c*16 +: 16]  = cdr;
    client_req[c]         = 1'b1;
    if (push) begin
      e.ack = '0;
      e.ack[c] = 1'b1;
      e.err = err;
      e.data = data;
      exp_q.push_back(e);
    end
  endtask

  // Wait for client c's ack; exp_lat < 0 skips the latency comparison.
  task automatic wait_ack(input int c, input int exp_lat);
    int n;
    n = 0;
    while (n < 100 && !client_ack[c]) begin
      @(negedge clk);
      n++;
    end
    if (!client_ack[c]) begin
      main_total++;
      main_bad++;
      $display("FAIL ack_timeout: client %0d no ack within %0d cycles", c, n);
    end else begin
      if (exp_lat >= 0) check($sformatf("latency_c%0d", c), 32'(n), 32'(exp_lat));
      check("busy_at_ack", 32'(busy), 32'h1);
    end
    client_req[c] = 1'b0;
    @(negedge clk);
    check("busy_after_ack", 32'(busy), 32'h0);
  endtask

  initial begin
    int acks;
    rst = 1'b1;
    client_req = '0;
    client_is_cons = '0;
    client_addr = '0;
    client_car = '0;
    client_cdr = '0;
    block_done = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    issue(1, 1'b0, 12'h001, 16'h0, 16'h0, 1'b1, 1'b0, 16'hBEEF);
    wait_ack(1, 3);

    issue(0, 1'b1, 12'h000, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0, 16'h0001);
    wait_ack(0, 4);

    issue(1, 1'b0, 12'h002, 16'h0, 16'h0, 1'b1, 1'b0, 16'hDEAD);
    wait_ack(1, 3);

    issue(0, 1'b0, 12'h001, 16'h0, 16'h0, 1'b1, 1'b0, 16'hBEEF);
    issue(1, 1'b0, 12'h003, 16'h0, 16'h0, 1'b1, 1'b0, 16'hBEEF);
    wait_ack(0, 3);
    wait_ack(1, -1);

    issue(0, 1'b0, 12'h001, 16'h0, 16'h0, 1'b1, 1'b0, 16'hBEEF);
    issue(1, 1'b0, 12'h002, 16'h0, 16'h0, 1'b1, 1'b0, 16'hDEAD);
    issue(0, 1'b0, 12'h001, 16'h0, 16'h0, 1'b1, 1'b0, 16'hBEEF);
    issue(1, 1'b0, 12'h002, 16'h0, 16'h0, 1'b1, 1'b0, 16'hDEAD);
    acks = 0;
    for (int i = 0; i < 100 && acks < 4; i++) begin
      @(negedge clk);
      if (client_ack != '0) acks++;
    end
    check("four_ops_acks", 32'(acks), 32'd4);
    client_req = '0;
    repeat (2) @(negedge clk);
    check("four_ops_idle", 32'(busy), 32'h0);

    block_done = 1'b1;
    issue(0, 1'b1, 12'h000, 16'h1111, 16'h2222, 1'b1, 1'b1, 16'h0000);
    wait_ack(0, TIMEOUT + 2);
    block_done = 1'b0;

    block_done = 1'b1;
    issue(1, 1'b1, 12'h000, 16'h3333, 16'h4444, 1'b0, 1'b0, 16'h0000);
    repeat (5) @(negedge clk);
    check("mid_cons_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    rst = 1'b0;
    client_req = '0;
    block_done = 1'b0;
    repeat (20) @(negedge clk);

    issue(0, 1'b0, 12'h001, 16'h0, 16'h0, 1'b1, 1'b0, 16'hBEEF);
    wait_ack(0, 3);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    total = main_total + mon_total;
    bad   = main_bad + mon_bad;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
